// File: rtl/seq_mult_datapath.sv
// Shift-add datapath of the sequential multiplier. It answers the control unit's
// Load_Enable/Enable handshake and returns the step Counter that the control unit
// uses to decide when to stop.
// The optional macro SEQ_MULT_SIGNED_EN selects two's-complement operands: A is
// sign-extended on load, and on the final step A is subtracted instead of added.
// When the macro is undefined the datapath multiplies unsigned operands.
module seq_mult_datapath #(
  parameter int unsigned Word_Length   = 8,
  parameter int unsigned Counter_Width = 4
) (
  input  logic                       clk,
  input  logic                       reset_Input,
  input  logic                       Load_Enable_input,
  input  logic                       Enable_input,
  input  logic [Word_Length-1:0]     Multiplicand_input,
  input  logic [Word_Length-1:0]     Multiplier_input,
  output logic [Counter_Width-1:0]   Counter,
  output logic [2*Word_Length-1:0]   Product_output,
  output logic                       Done_output
);

  localparam int unsigned ProdWidth = 2 * Word_Length;
  localparam logic [Counter_Width-1:0] LastCount = Counter_Width'(Word_Length - 1);
  localparam logic [Counter_Width-1:0] CountOne  = 1;

  logic [ProdWidth-1:0]   a_reg;
  logic [Word_Length-1:0] b_reg;
  logic [ProdWidth-1:0]   a_load;
  logic [ProdWidth-1:0]   step_sum;
  logic                   last_step;

  assign last_step = (Counter == LastCount);

  // Widen the multiplicand to the full product width when operands are loaded.
  always_comb begin
    a_load = '0;
`ifdef SEQ_MULT_SIGNED_EN
    a_load = {{Word_Length{Multiplicand_input[Word_Length-1]}}, Multiplicand_input};
`else
    a_load = {{Word_Length{1'b0}}, Multiplicand_input};
`endif
  end

  // Next accumulator value for one step. The multiplier's top bit has negative
  // weight in two's complement, so its partial product is subtracted.
  always_comb begin
    step_sum = Product_output;
    if (b_reg[0]) begin
`ifdef SEQ_MULT_SIGNED_EN
      if (last_step) begin
        step_sum = Product_output - a_reg;
      end else begin
        step_sum = Product_output + a_reg;
      end
`else
      step_sum = Product_output + a_reg;
`endif
    end
  end

  // Operand, accumulator, counter and done registers. Load has priority over a
  // step, and steps are ignored once the product is complete.
  always_ff @(posedge clk or negedge reset_Input) begin
    if (!reset_Input) begin
      a_reg          <= '0;
      b_reg          <= '0;
      Product_output <= '0;
      Counter        <= '0;
      Done_output    <= 1'b0;
    end else if (Load_Enable_input) begin
      a_reg          <= a_load;
      b_reg          <= Multiplier_input;
      Product_output <= '0;
      Counter        <= '0;
      Done_output    <= 1'b0;
    end else if (Enable_input && !Done_output) begin
      Product_output <= step_sum;
      a_reg          <= a_reg << 1;
      b_reg          <= b_reg >> 1;
      if (last_step) begin
        Done_output <= 1'b1;
      end else begin
        Counter <= Counter + CountOne;
      end
    end
  end

endmodule

// File: doc/seq_mult_datapath.md
Name: seq_mult_datapath

Overview:
Shift-add datapath for the sequential multiplier; the responder side of the Control_Unit handshake. It consumes Load_Enable and Enable from the control unit and returns the step Counter the control unit uses to terminate. It holds the operand and accumulator registers and presents the 2*Word_Length product with a done flag.

Parameters:
Word_Length, 8, operand width in bits (2..15)
Counter_Width, 4, width of Counter output; must satisfy 2**Counter_Width > Word_Length-1

Ports:
clk  input  1  system clock, all state on rising edge
reset_Input  input  1  asynchronous, active-low reset
Load_Enable_input  input  1  load operands, clear accumulator and Counter
Enable_input  input  1  perform one shift-add step this cycle
Multiplicand_input  input  Word_Length  operand A, sampled on load
Multiplier_input  input  Word_Length  operand B, sampled on load
Counter  output  Counter_Width  index of next bit to process, to Control_Unit
Product_output  output  2*Word_Length  accumulator value
Done_output  output  1  high once the final step has executed

Behaviour:
- Reset (reset_Input=0, async): A_reg, B_reg, Product_output, Counter=0; Done_output=0; all outputs registered.
- Load (Load_Enable_input=1 at edge): A_reg <= Multiplicand_input zero-extended to 2*Word_Length; B_reg <= Multiplier_input; Product_output <= 0; Counter <= 0; Done_output <= 0.
- Step (Enable_input=1, Load_Enable_input=0, Done_output=0):
  - If B_reg[0]=1, Product_output <= Product_output + A_reg (mod 2**(2*Word_Length)); otherwise unchanged.
  - A_reg <= A_reg << 1; B_reg <= B_reg >> 1 (logical).
  - If Counter < Word_Length-1, Counter <= Counter+1.
  - If Counter == Word_Length-1, Counter holds and Done_output <= 1.
- Exactly Word_Length steps complete a product. Counter reaches Word_Length-1 after Word_Length-1 steps. Control unit issues the last Enable while Counter == Word_Length-1. Result is valid on the cycle Done_output rises.
- Enable_input while Done_output=1: ignored. All registers hold, no wrap-around.
- Simultaneous Load_Enable_input and Enable_input: load wins, no step.
- Neither asserted: all registers hold.
- Enable_input with no load since reset: steps on zero operands; Product_output stays 0, Counter and Done_output behave normally.
- Load mid-operation: aborts the current product and restarts cleanly on the next cycle.
- Reset mid-operation: immediate return to reset values regardless of clk.
- Operands change while stepping: no effect; sampled only on load.

Optional Feature:
SEQ_MULT_SIGNED_EN
- Defined: operands are two's complement. A_reg is sign-extended on load. On the final step (Counter == Word_Length-1), Product_output <= Product_output - A_reg when B_reg[0]=1, instead of adding. Product_output is a signed 2*Word_Length result.
- Undefined: unsigned operation exactly as specified above.

Test Plan:
- Reset 0 asserted mid-clock with outputs nonzero -> all outputs 0 immediately, before the next edge.
- Load A=13, B=11, then 8 Enable pulses -> Counter 0,1,..,7 then holds 7; Done_output=1 after 8th step; Product_output=143 (0x008F).
- Load A=255, B=255, 8 steps, then 3 extra Enable pulses -> Product_output=65025 (0xFE01); Counter stays 7; Done_output stays 1; no change from extra pulses.
- Load A=200, B=0, 8 steps -> Product_output=0, Done_output=1. Then, with Load and Enable asserted together (A=3, B=2) -> load only, Counter=0, Done_output=0; 8 steps -> Product_output=6.
- Load A=9, B=9, 4 steps, then Load A=2, B=7 and 8 steps -> Product_output=14, no residue from the aborted run. Separately, reset after 4 steps of a run -> Counter=0, Product_output=0, Done_output=0.
- With SEQ_MULT_SIGNED_EN: A=-3 (0xFD), B=5, 8 steps -> Product_output=0xFFF1 (-15); A=-128, B=-128 -> 0x4000 (16384).
